// File: rtl/serial_adder_arbiter.sv
// serial_adder_arbiter
// Round-robin controller sharing a single four_bit_serial_adder between NREQ
// requesters. Grants one requester per operation, latches its operands, pulses
// the adder start, waits for done (or a watchdog timeout) and returns the sum
// with a one-cycle one-hot ack.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req[NREQ]          per-requester request level
//   req_a/req_b        packed 4-bit operands, requester i in [4i+3:4i]
//   ack[NREQ]          one-cycle one-hot completion pulse
//   res[4], err        sum and timeout flag, valid with ack
//   busy               high in every state except IDLE
//   gnt_id[IDW]        index of the current/last granted requester
//   add_start/a/b      registered drive to the adder
//   add_done, add_s    adder completion and sum
module serial_adder_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic [3:0]        res,
    output logic              err,
    output logic              busy,
    output logic [IDW-1:0]    gnt_id,
    output logic              add_start,
    output logic [3:0]        add_a,
    output logic [3:0]        add_b,
    input  logic              add_done,
    input  logic [3:0]        add_s
);

    localparam int unsigned WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gnt_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [NREQ-1:0] ack_d;
    logic [3:0]      res_d, add_a_d, add_b_d;
    logic            err_d, busy_d, start_d;

    logic [IDW-1:0]  pick;
    logic            hit;
    logic [3:0]      pick_a, pick_b;

    // Round-robin pick: first pass covers indices at/after the pointer, second pass wraps.
    always_comb begin
        pick   = '0;
        hit    = 1'b0;
        pick_a = '0;
        pick_b = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!hit && req[k] && (IDW'(k) >= ptr_q)) begin
                pick = IDW'(k);
                hit  = 1'b1;
            end
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!hit && req[k]) begin
                pick = IDW'(k);
                hit  = 1'b1;
            end
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            if (IDW'(k) == pick) begin
                pick_a = req_a[4*k +: 4];
                pick_b = req_b[4*k +: 4];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_id;
        wdog_d  = wdog_q;
        ack_d   = '0;
        res_d   = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        add_a_d = add_a;
        add_b_d = add_b;

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    gnt_d   = pick;
                    add_a_d = pick_a;
                    add_b_d = pick_b;
                    start_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // add_done may still be high from the previous op; ignore it here.
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wdog_d = wdog_q + WDW'(1);
                if (add_done) begin
                    res_d   = add_s;
                    state_d = RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
                if (state_d == RESP) begin
                    for (int k = 0; k < int'(NREQ); k++) begin
                        ack_d[k] = (IDW'(k) == gnt_id);
                    end
                end
            end
            RESP: begin
                ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wdog_q    <= '0;
            gnt_id    <= '0;
            ack       <= '0;
            res       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wdog_q    <= wdog_d;
            gnt_id    <= gnt_d;
            ack       <= ack_d;
            res       <= res_d;
            err       <= err_d;
            busy      <= busy_d;
            add_start <= start_d;
            add_a     <= add_a_d;
            add_b     <= add_b_d;
        end
    end

endmodule

// File: doc/serial_adder_arbiter.md
Name: serial_adder_arbiter

Overview:
- Round-robin controller that shares one four_bit_serial_adder instance between NREQ requesters.
- Arbitrates requests and latches the winner's operands.
- Pulses the adder's start, waits for done, and returns the 4-bit sum with a one-cycle ack to the granted requester.
- Includes a watchdog so a stuck adder cannot hang the arbiter.
- Sits between client blocks and the single adder instance at the same hierarchy level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant index; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 8, max RUN-state cycles waiting for add_done before error completion (>=5).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level.
- req_a  input  4*NREQ  operand A, requester i in bits [4i+3:4i].
- req_b  input  4*NREQ  operand B, same packing.
- ack  output  NREQ  one-cycle completion pulse, one-hot.
- res  output  4  sum, valid only while ack is nonzero.
- err  output  1  timeout flag, valid with ack.
- busy  output  1  high in every state except IDLE.
- gnt_id  output  IDW  index of current/last granted requester.
- add_start  output  1  to adder start.
- add_a  output  4  to adder A, registered.
- add_b  output  4  to adder B, registered.
- add_done  input  1  from adder done.
- add_s  input  4  from adder S.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - ack, res, err, busy, add_start, add_a, add_b, gnt_id all 0.
  - Round-robin pointer is 0, so requester 0 has top priority.
  - Watchdog counter is 0.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req is high, select the first requester at or after pointer, wrapping modulo NREQ.
  - Register gnt_id and latch add_a/add_b from that requester's operands.
  - Go to LOAD.
  - No req: stay in IDLE.
- LOAD:
  - add_start=1 for exactly this cycle; add_a/add_b stable.
  - add_done is ignored, since it may be stale from the previous op.
  - Go to RUN, clear watchdog.
- RUN:
  - add_start=0. Increment watchdog each cycle.
  - add_done=1: capture add_s into res, err=0, go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: res=0, err=1, go to RESP.
- RESP:
  - ack[gnt_id]=1 for exactly one cycle; res/err held.
  - Pointer <= gnt_id+1, wrapping to 0 after NREQ-1.
  - Go to IDLE. ack, res, err return to 0 in the following cycle.
- Latency, nominal adder: req seen in IDLE cycle 0 -> LOAD cycle 1 -> RUN cycles 2..5 (done seen cycle 5) -> ack in cycle 6.
  - Back-to-back ops take 7 cycles each.
- Arithmetic: res = (A+B) mod 16; carry-out is not available.
- Requester handshake:
  - Hold req and operands until ack.
  - Drop req in the cycle after ack, else it is treated as a new request.
  - Operands are sampled only at the IDLE grant edge; later changes are ignored.
- req dropped mid-operation: the op still completes and ack still pulses.
- Simultaneous requests: only one grant per IDLE cycle. Losers wait; no starvation, with a bound of NREQ operations.
- Reset asserted mid-operation: immediate return to IDLE.
  - No ack is emitted for the aborted op.
  - The adder is not reset. The next op re-issues add_start, which reinitialises the adder.
- ack is never asserted for more than one requester or more than one cycle per op.

Test Plan:
1. After reset, req[0]=1 with A=3, B=5 -> add_start high cycle 1 only; ack=0001, res=8, err=0 in cycle 6; busy cycles 1..6.
2. req[1], A=9, B=9 -> res=2 (mod 16), ack=0010 in cycle 6.
3. After reset, req=1111 held until each ack -> acks in order 0,1,2,3 at cycles 6, 13, 20, 27; each res matches its operands.
4. Last grant=2, then req[0] and req[3] raised together -> requester 3 acked first, requester 0 7 cycles later.
5. add_done forced 0 -> ack with err=1, res=0 at cycle 2+TIMEOUT (cycle 10 default); next request proceeds normally.
6. rst_n pulsed low during RUN -> all outputs 0 asynchronously, no ack; after release, a held req restarts at LOAD and completes with the correct sum.
